// File: rtl/toggle_pulse_encoder.sv
// toggle_pulse_encoder: converts single-cycle event pulses into level
// transitions on toggle_out. Transitions are spaced at least HOLD_CYCLES
// apart. Events arriving during a hold are buffered in a saturating counter.
module toggle_pulse_encoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  input  logic              clr_ovf,
  output logic              toggle_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [7:0]        HC_RELOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic              r_toggle;
  logic [7:0]        r_hc;
  logic [PEND_W-1:0] r_pending;
  logic              r_overflow;
  logic              r_busy;

  state_t            w_state_nx;
  logic              w_toggle_nx;
  logic [7:0]        w_hc_nx;
  logic [PEND_W-1:0] w_pending_nx;
  logic              w_overflow_nx;
  logic              w_busy_nx;
  logic              w_ev_nz;
  logic [PEND_W-1:0] w_pending_serve;

  // Event availability and the pending value left behind after a serve.
  // Serving consumes one event out of (pending + pulse_in): with a pulse the
  // count is unchanged, without one it drops by one.
  always_comb begin
    w_ev_nz         = (r_pending != {PEND_W{1'b0}}) || pulse_in;
    w_pending_serve = r_pending;
    if (pulse_in) begin
      w_pending_serve = r_pending;
    end else if (r_pending != {PEND_W{1'b0}}) begin
      w_pending_serve = r_pending - PEND_ONE;
    end else begin
      w_pending_serve = {PEND_W{1'b0}};
    end
  end

  // Next-state logic: IDLE serves immediately, HOLD counts down and buffers.
  always_comb begin
    w_state_nx    = r_state;
    w_toggle_nx   = r_toggle;
    w_hc_nx       = r_hc;
    w_pending_nx  = r_pending;
    w_overflow_nx = r_overflow & ~clr_ovf;
    case (r_state)
      ST_IDLE: begin
        if (w_ev_nz) begin
          w_toggle_nx  = ~r_toggle;
          w_hc_nx      = HC_RELOAD;
          w_pending_nx = w_pending_serve;
          w_state_nx   = ST_HOLD;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (r_hc != 8'd0) begin
          w_hc_nx = r_hc - 8'd1;
          if (pulse_in) begin
            if (r_pending == PEND_MAX) begin
              // Buffer full: the event is lost; a drop outranks a clear.
              w_overflow_nx = 1'b1;
            end else begin
              w_pending_nx = r_pending + PEND_ONE;
            end
          end else begin
            w_pending_nx = r_pending;
          end
        end else if (w_ev_nz) begin
          w_toggle_nx  = ~r_toggle;
          w_hc_nx      = HC_RELOAD;
          w_pending_nx = w_pending_serve;
          w_state_nx   = ST_HOLD;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx   = ST_IDLE;
        w_toggle_nx  = 1'b0;
        w_hc_nx      = 8'd0;
        w_pending_nx = {PEND_W{1'b0}};
      end
    endcase
    w_busy_nx = (w_state_nx == ST_HOLD) || (w_pending_nx != {PEND_W{1'b0}});
  end

  // State and output registers; async reset abandons any hold and backlog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_toggle   <= 1'b0;
      r_hc       <= 8'd0;
      r_pending  <= {PEND_W{1'b0}};
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_toggle   <= w_toggle_nx;
      r_hc       <= w_hc_nx;
      r_pending  <= w_pending_nx;
      r_overflow <= w_overflow_nx;
      r_busy     <= w_busy_nx;
    end
  end

  assign toggle_out = r_toggle;
  assign busy       = r_busy;
  assign pending    = r_pending;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_toggle_pulse_encoder.sv
// Directed testbench for toggle_pulse_encoder (HOLD_CYCLES=4, PEND_W=3).
// Cycle c is the clock period after the c-th rising edge following reset
// release; outputs are sampled and inputs driven 1 time unit after that edge.
module tb_toggle_pulse_encoder;

  logic       clk;
  logic       reset;
  logic       pulse_in;
  logic       clr_ovf;
  logic       toggle_out;
  logic       busy;
  logic [2:0] pending;
  logic       overflow;

  int tests_run;
  int tests_failed;

  toggle_pulse_encoder #(.HOLD_CYCLES(4), .PEND_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .pulse_in  (pulse_in),
    .clr_ovf   (clr_ovf),
    .toggle_out(toggle_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset    = 1'b0;
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({toggle_out, busy, pending, overflow} !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_hold: got t=%b b=%b p=%0d o=%b want all 0", toggle_out, busy, pending, overflow);
    end
    reset = 1'b1;
    tick;
    tests_run++;
    if ({toggle_out, busy, pending, overflow} !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_release: got t=%b b=%b p=%0d o=%b want all 0", toggle_out, busy, pending, overflow);
    end
  endtask

  task automatic test_single;
    logic et, eb;
    do_reset;
    for (int c = 0; c <= 20; c++) begin
      et = (c >= 11);
      eb = (c >= 11) && (c <= 14);
      tests_run++;
      if (toggle_out !== et) begin
        tests_failed++;
        $display("FAIL single_toggle c=%0d: got %b want %b", c, toggle_out, et);
      end
      tests_run++;
      if (busy !== eb) begin
        tests_failed++;
        $display("FAIL single_busy c=%0d: got %b want %b", c, busy, eb);
      end
      tests_run++;
      if (pending !== 3'd0) begin
        tests_failed++;
        $display("FAIL single_pending c=%0d: got %0d want 0", c, pending);
      end
      pulse_in = (c == 10);
      tick;
    end
    pulse_in = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic       et, eb;
    logic [2:0] ep;
    do_reset;
    for (int c = 0; c <= 26; c++) begin
      et = ((c >= 11) && (c <= 14)) || (c >= 19);
      eb = (c >= 11) && (c <= 22);
      if (c == 12)                 ep = 3'd1;
      else if (c == 13 || c == 14) ep = 3'd2;
      else if (c >= 15 && c <= 18) ep = 3'd1;
      else                         ep = 3'd0;
      tests_run++;
      if (toggle_out !== et) begin
        tests_failed++;
        $display("FAIL burst_toggle c=%0d: got %b want %b", c, toggle_out, et);
      end
      tests_run++;
      if (busy !== eb) begin
        tests_failed++;
        $display("FAIL burst_busy c=%0d: got %b want %b", c, busy, eb);
      end
      tests_run++;
      if (pending !== ep) begin
        tests_failed++;
        $display("FAIL burst_pending c=%0d: got %0d want %0d", c, pending, ep);
      end
      pulse_in = (c >= 10) && (c <= 12);
      tick;
    end
    pulse_in = 1'b0;
  endtask

  task automatic test_overflow;
    int   trans;
    logic prev;
    trans = 0;
    do_reset;
    prev = toggle_out;
    for (int c = 0; c <= 60; c++) begin
      if (toggle_out !== prev) trans++;
      prev = toggle_out;
      if (c == 20) begin
        tests_run++;
        if (pending !== 3'd7 || overflow !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovf_saturate c=20: got p=%0d o=%b want p=7 o=0", pending, overflow);
        end
      end
      if (c == 21 || c == 54) begin
        tests_run++;
        if (overflow !== 1'b1) begin
          tests_failed++;
          $display("FAIL ovf_set c=%0d: got %b want 1", c, overflow);
        end
      end
      if (c == 51) begin
        tests_run++;
        if (busy !== 1'b0 || pending !== 3'd0 || toggle_out !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovf_drain c=51: got b=%b p=%0d t=%b want b=0 p=0 t=0", busy, pending, toggle_out);
        end
      end
      if (c == 56) begin
        tests_run++;
        if (overflow !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovf_clear c=56: got %b want 0", overflow);
        end
      end
      pulse_in = (c >= 10) && (c <= 21);
      clr_ovf  = (c == 55);
      tick;
    end
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    tests_run++;
    if (trans !== 10) begin
      tests_failed++;
      $display("FAIL ovf_transitions: got %0d want 10", trans);
    end
  endtask

  task automatic test_serve_edge;
    logic et, eb;
    do_reset;
    for (int c = 0; c <= 22; c++) begin
      et = (c >= 11) && (c <= 14);
      eb = (c >= 11) && (c <= 18);
      tests_run++;
      if (toggle_out !== et) begin
        tests_failed++;
        $display("FAIL serve_toggle c=%0d: got %b want %b", c, toggle_out, et);
      end
      tests_run++;
      if (busy !== eb) begin
        tests_failed++;
        $display("FAIL serve_busy c=%0d: got %b want %b", c, busy, eb);
      end
      tests_run++;
      if (pending !== 3'd0) begin
        tests_failed++;
        $display("FAIL serve_pending c=%0d: got %0d want 0", c, pending);
      end
      pulse_in = (c == 10) || (c == 14);
      tick;
    end
    pulse_in = 1'b0;
  endtask

  task automatic test_reset_midop;
    do_reset;
    for (int c = 0; c < 20; c++) begin
      pulse_in = (c >= 10) && (c <= 14);
      tick;
    end
    pulse_in = 1'b0;
    tests_run++;
    if (toggle_out !== 1'b1 || pending !== 3'd2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midop_pre c=20: got t=%b p=%0d b=%b want t=1 p=2 b=1", toggle_out, pending, busy);
    end
    reset = 1'b0;
    #2;
    tests_run++;
    if ({toggle_out, busy, pending, overflow} !== 6'b000000) begin
      tests_failed++;
      $display("FAIL midop_async: got t=%b b=%b p=%0d o=%b want all 0", toggle_out, busy, pending, overflow);
    end
    tick;
    reset = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tests_run++;
      if (toggle_out !== 1'b0 || busy !== 1'b0 || pending !== 3'd0) begin
        tests_failed++;
        $display("FAIL midop_quiet c=%0d: got t=%b b=%b p=%0d want 0 0 0", c, toggle_out, busy, pending);
      end
      tick;
    end
    pulse_in = 1'b1;
    tick;
    pulse_in = 1'b0;
    tests_run++;
    if (toggle_out !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midop_resume: got t=%b b=%b want t=1 b=1", toggle_out, busy);
    end
  endtask

  task automatic test_clear_collision;
    do_reset;
    for (int c = 0; c <= 23; c++) begin
      if (c == 21) begin
        tests_run++;
        if (overflow !== 1'b1 || pending !== 3'd7) begin
          tests_failed++;
          $display("FAIL coll_pre c=21: got o=%b p=%0d want o=1 p=7", overflow, pending);
        end
      end
      if (c == 22) begin
        tests_run++;
        if (overflow !== 1'b1 || pending !== 3'd7) begin
          tests_failed++;
          $display("FAIL coll_setwins c=22: got o=%b p=%0d want o=1 p=7", overflow, pending);
        end
      end
      if (c == 23) begin
        tests_run++;
        if (overflow !== 1'b0 || pending !== 3'd6) begin
          tests_failed++;
          $display("FAIL coll_clear c=23: got o=%b p=%0d want o=0 p=6", overflow, pending);
        end
      end
      pulse_in = (c >= 10) && (c <= 21);
      clr_ovf  = (c == 21) || (c == 22);
      tick;
    end
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    pulse_in     = 1'b0;
    clr_ovf      = 1'b0;
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_serve_edge;
    test_reset_midop;
    test_clear_collision;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
